// File: rtl/irq_timer.sv
// Memory-mapped 16-bit down-counter with prescaler, auto-reload and
// an active-low interrupt line; four byte-wide registers on an 8-bit bus.
module irq_timer #(
    parameter logic [15:0] BASE_ADDR = 16'h8000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] A_BUS,
    input  logic [7:0]  D_IN,
    input  logic        RW,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    output logic        nIRQ
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [15:0]   latch;
    logic [15:0]   count;
    logic [PW-1:0] pre;
    logic          en;
    logic          free;
    logic          ie;
    logic          uf;

    logic       sel;
    logic [1:0] idx;
    logic       wr;
    logic       latl_wr;
    logic       lath_wr;
    logic       ctrl_wr;
    logic       stat_wr;
    logic       tick;
    logic       stop;
    logic       step;
    logic       under;
    logic [7:0] rdata;

    assign sel     = (A_BUS[15:2] == BASE_ADDR[15:2]);
    assign idx     = A_BUS[1:0];
    assign wr      = sel & ~RW;
    assign latl_wr = wr & (idx == 2'd0);
    assign lath_wr = wr & (idx == 2'd1);
    assign ctrl_wr = wr & (idx == 2'd2);
    assign stat_wr = wr & (idx == 2'd3);

    // A LATH load or an explicit stop swallows the tick of the same cycle.
    assign tick  = en & (pre == PS_LAST);
    assign stop  = ctrl_wr & ~D_IN[0];
    assign step  = tick & ~lath_wr & ~stop;
    assign under = step & (count == 16'h0000);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            latch <= '0;
            count <= '0;
            pre   <= '0;
            en    <= 1'b0;
            free  <= 1'b0;
            ie    <= 1'b0;
            uf    <= 1'b0;
        end else begin
            if (latl_wr)
                latch[7:0] <= D_IN;
            if (lath_wr)
                latch[15:8] <= D_IN;

            if (lath_wr || !en || stop || tick)
                pre <= '0;
            else
                pre <= pre + 1'b1;

            if (lath_wr)
                count <= {D_IN, latch[7:0]};
            else if (step && count != 16'h0000)
                count <= count - 1'b1;
            else if (under)
                count <= free ? latch : 16'h0000;

            if (lath_wr)
                en <= 1'b1;
            else if (ctrl_wr)
                en <= D_IN[0];
            else if (under && !free)
                en <= 1'b0;

            if (ctrl_wr) begin
                free <= D_IN[1];
                ie   <= D_IN[2];
            end

            // Underflow wins over a same-cycle clear so no event is lost.
            if (under)
                uf <= 1'b1;
            else if (stat_wr && D_IN[0])
                uf <= 1'b0;
        end
    end

    always_comb begin
        rdata = 8'h00;
        unique case (idx)
            2'd0: rdata = count[7:0];
            2'd1: rdata = count[15:8];
            2'd2: rdata = {5'b0, ie, free, en};
            2'd3: rdata = {7'b0, uf};
        endcase
    end

    assign D_OE  = sel & RW;
    assign D_OUT = D_OE ? rdata : 8'h00;
    assign nIRQ  = ~(uf & ie);

endmodule

// File: tb/tb_irq_timer.sv
// Bench for irq_timer: two instances (prescale 1 and 4) driven by directed
// scenarios and random bus traffic, checked against an integer model.
module tb_irq_timer;

    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] A_BUS;
    logic [7:0]  D_IN;
    logic        RW;
    logic [7:0]  d_out1, d_out4;
    logic        d_oe1, d_oe4;
    logic        nirq1, nirq4;

    localparam logic [15:0] B1 = 16'h8000;
    localparam logic [15:0] B4 = 16'h9000;

    irq_timer #(.BASE_ADDR(B1), .PRESCALE(1)) u1 (
        .clk(clk), .RST(RST), .A_BUS(A_BUS), .D_IN(D_IN), .RW(RW),
        .D_OUT(d_out1), .D_OE(d_oe1), .nIRQ(nirq1)
    );

    irq_timer #(.BASE_ADDR(B4), .PRESCALE(4)) u4 (
        .clk(clk), .RST(RST), .A_BUS(A_BUS), .D_IN(D_IN), .RW(RW),
        .D_OUT(d_out4), .D_OE(d_oe4), .nIRQ(nirq4)
    );

    always #10 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    int          ps[2]   = '{1, 4};
    logic [15:0] base[2] = '{B1, B4};

    // Reference model: plain integers and flags
    int m_count[2];
    int m_latch[2];
    int m_pc[2];
    bit m_en[2];
    bit m_free[2];
    bit m_ie[2];
    bit m_uf[2];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_count[k] = 0; m_latch[k] = 0; m_pc[k] = 0;
            m_en[k] = 0; m_free[k] = 0; m_ie[k] = 0; m_uf[k] = 0;
        end
    endtask

    task automatic model_step(input logic [15:0] a, input logic [7:0] d,
                              input logic rw);
        bit sel, wr, tick, stop, step, under;
        bit latlw, lathw, ctrlw, statw;
        int id, old_latch;
        for (int k = 0; k < 2; k++) begin
            sel   = (a / 4) == (base[k] / 4);
            wr    = sel && !rw;
            id    = a % 4;
            latlw = wr && id == 0;
            lathw = wr && id == 1;
            ctrlw = wr && id == 2;
            statw = wr && id == 3;
            old_latch = m_latch[k];
            tick  = m_en[k] && (m_pc[k] == ps[k] - 1);
            stop  = ctrlw && !d[0];
            step  = tick && !lathw && !stop;
            under = step && m_count[k] == 0;

            if (!m_en[k] || lathw || stop) m_pc[k] = 0;
            else m_pc[k] = (m_pc[k] + 1) % ps[k];

            if (latlw) m_latch[k] = (old_latch / 256) * 256 + d;
            if (lathw) begin
                m_latch[k] = d * 256 + old_latch % 256;
                m_count[k] = m_latch[k];
            end else if (step) begin
                if (under) m_count[k] = m_free[k] ? old_latch : 0;
                else m_count[k] = m_count[k] - 1;
            end

            if (lathw) m_en[k] = 1;
            else if (ctrlw) m_en[k] = d[0];
            else if (under && !m_free[k]) m_en[k] = 0;

            if (under) m_uf[k] = 1;
            else if (statw && d[0]) m_uf[k] = 0;

            if (ctrlw) begin
                m_free[k] = d[1];
                m_ie[k]   = d[2];
            end
        end
    endtask

    function automatic logic [7:0] mreg(input int k, input int i);
        case (i)
            0: return 8'(m_count[k] % 256);
            1: return 8'(m_count[k] / 256);
            2: return {5'b0, m_ie[k], m_free[k], m_en[k]};
            default: return {7'b0, m_uf[k]};
        endcase
    endfunction

    // One clock edge with the given bus access, then the irq lines.
    task automatic cycle(input logic [15:0] a, input logic [7:0] d,
                         input logic rw);
        A_BUS = a; D_IN = d; RW = rw;
        @(posedge clk);
        model_step(a, d, rw);
        cyc++;
        #1;
        A_BUS = 16'h0000; D_IN = 8'h00; RW = 1'b1;
        check("nirq1", nirq1, !(m_uf[0] && m_ie[0]));
        check("nirq4", nirq4, !(m_uf[1] && m_ie[1]));
    endtask

    task automatic read_all();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                A_BUS = base[k] + 16'(i); RW = 1'b1;
                #1;
                check($sformatf("rd%0d_%0d", k, i),
                      k ? d_out4 : d_out1, mreg(k, i));
                check($sformatf("oe%0d_%0d", k, i),
                      k ? d_oe4 : d_oe1, 1'b1);
                check($sformatf("oe_other%0d_%0d", k, i),
                      k ? d_oe1 : d_oe4, 1'b0);
            end
        end
        A_BUS = 16'h0000;
    endtask

    task automatic run(input logic [15:0] a, input logic [7:0] d,
                       input logic rw);
        cycle(a, d, rw);
        read_all();
    endtask

    task automatic wr(input int k, input int i, input logic [7:0] d);
        run(base[k] + 16'(i), d, 1'b0);
    endtask

    task automatic idle();
        run(16'h0000, 8'h00, 1'b1);
    endtask

    task automatic rd(input int k, input int i, output logic [7:0] v);
        A_BUS = base[k] + 16'(i); RW = 1'b1;
        #1;
        v = k ? d_out4 : d_out1;
        A_BUS = 16'h0000;
    endtask

    // Cycles between two underflows, with a UF clear right after the first.
    task automatic measure(input int k, input int exp, input string tag);
        int t0, t1;
        logic [7:0] v;
        t0 = -1; t1 = -1;
        wr(k, 3, 8'h01);
        rd(k, 3, v);
        if (v[0]) t0 = cyc;
        for (int i = 0; i < 100 && t0 < 0; i++) begin
            idle();
            rd(k, 3, v);
            if (v[0]) t0 = cyc;
        end
        wr(k, 3, 8'h01);
        for (int i = 0; i < 100 && t1 < 0; i++) begin
            idle();
            rd(k, 3, v);
            if (v[0]) t1 = cyc;
        end
        check(tag, t1 - t0, exp);
    endtask

    initial begin
        logic [7:0] v;
        int found;
        int r, k, i;

        RST = 1'b1; A_BUS = 16'h0000; D_IN = 8'h00; RW = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_nirq1", nirq1, 1'b1);
        check("rst_nirq4", nirq4, 1'b1);
        check("rst_oe1", d_oe1, 1'b0);
        check("rst_dout1", d_out1, 8'h00);
        check("rst_dout4", d_out4, 8'h00);
        RST = 1'b0;
        read_all();

        // Free-run, prescale 1, latch 3
        wr(0, 0, 8'h03);
        wr(0, 1, 8'h00);
        rd(0, 0, v); check("lath_load", v, 8'h03);
        wr(0, 2, 8'h07);
        rd(0, 0, v); check("cnt_2", v, 8'h02);
        idle(); rd(0, 0, v); check("cnt_1", v, 8'h01);
        idle(); rd(0, 0, v); check("cnt_0", v, 8'h00);
        idle(); rd(0, 0, v); check("reload_3", v, 8'h03);
        rd(0, 3, v); check("uf_set", v, 8'h01);
        check("nirq_low", nirq1, 1'b0);
        measure(0, 4, "period_p1");

        // One-shot
        wr(0, 2, 8'h00);
        wr(0, 3, 8'h01);
        wr(0, 0, 8'h02);
        wr(0, 1, 8'h00);
        wr(0, 2, 8'h05);
        idle();
        rd(0, 3, v); check("os_no_uf_yet", v, 8'h00);
        idle();
        rd(0, 3, v); check("os_uf", v, 8'h01);
        rd(0, 2, v); check("os_en_off", v, 8'h04);
        rd(0, 0, v); check("os_cnt0", v, 8'h00);
        wr(0, 3, 8'h01);
        repeat (10) idle();
        rd(0, 3, v); check("os_no_more_uf", v, 8'h00);
        rd(0, 1, v); check("os_cnt_hi0", v, 8'h00);

        // Same-cycle STAT clear and underflow; LATH write during a tick
        wr(0, 0, 8'h03);
        wr(0, 1, 8'h00);
        wr(0, 2, 8'h07);
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            idle();
            rd(0, 0, v);
            if (v == 8'h01) found = 1;
        end
        check("find_cnt1", found, 1);
        wr(0, 3, 8'h01);
        rd(0, 3, v); check("uf_cleared", v, 8'h00);
        wr(0, 3, 8'h01);
        rd(0, 3, v); check("uf_beats_clr", v, 8'h01);
        check("uf_beats_clr_irq", nirq1, 1'b0);
        wr(0, 0, 8'h05);
        wr(0, 1, 8'h00);
        rd(0, 0, v); check("lath_beats_tick", v, 8'h05);

        // Prescale 4, latch 1, IE off
        wr(1, 0, 8'h01);
        wr(1, 1, 8'h00);
        wr(1, 2, 8'h03);
        measure(1, 8, "period_p4");
        rd(1, 3, v); check("p4_uf", v, 8'h01);
        check("p4_ie_off", nirq4, 1'b1);

        // Asynchronous reset pulse mid-count
        cycle(16'h0000, 8'h00, 1'b1);
        #3 RST = 1'b1;
        #3;
        check("arst_nirq1", nirq1, 1'b1);
        check("arst_oe1", d_oe1, 1'b0);
        RST = 1'b0;
        model_reset();
        #1;
        for (int n = 0; n < 4; n++) begin
            rd(0, n, v); check($sformatf("arst_r1_%0d", n), v, 8'h00);
        end
        read_all();
        repeat (6) idle();
        rd(0, 2, v); check("arst_idle_en", v, 8'h00);
        rd(0, 0, v); check("arst_idle_cnt", v, 8'h00);

        // Decode boundaries
        A_BUS = B1 + 16'h4; RW = 1'b1; #1;
        check("dec_oe_p4", d_oe1, 1'b0);
        A_BUS = 16'h7FFF; #1;
        check("dec_oe_7fff", d_oe1, 1'b0);
        A_BUS = B1 + 16'h3; #1;
        check("dec_oe_p3", d_oe1, 1'b1);
        run(B1 + 16'h5, 8'hFF, 1'b0);
        run(B1 + 16'h6, 8'h07, 1'b0);
        run(16'h7FFD, 8'h01, 1'b0);
        run(16'h7FFE, 8'h07, 1'b0);
        run(B4 + 16'h5, 8'h01, 1'b0);
        rd(0, 2, v); check("dec_ctrl_same", v, 8'h00);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            k = $urandom_range(0, 1);
            i = $urandom_range(0, 3);
            if (r < 5) begin
                idle();
            end else if (r < 9) begin
                case (i)
                    0: wr(k, 0, 8'($urandom_range(0, 9)));
                    1: wr(k, 1, 8'h00);
                    2: wr(k, 2, 8'($urandom_range(0, 7)));
                    default: wr(k, 3, 8'($urandom_range(0, 255)));
                endcase
            end else begin
                run(16'($urandom), 8'($urandom), 1'($urandom));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
